coeff_rom_sequencer: RTL and testbench

- Drives the dual-port coefficient ROM (32-bit rows, 3-cycle registered read latency) that feeds the systolic array.
- On a start command it streams a contiguous block of coefficient rows as row pairs: port 1 reads even offsets, port 2 reads odd offsets.
- Returned data passes through a credit-protected output FIFO with a valid/ready interface, so the array can stall even though the ROM pipeline itself cannot.

---
 rtl/coeff_rom_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_coeff_rom_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_rom_sequencer.sv
// Coefficient ROM sequencer.
// Streams a contiguous block of coefficient rows out of a dual-port ROM as
// row pairs (port 1 = even offset, port 2 = odd offset). Each pair is
// buffered in a credit-protected output FIFO so the systolic array can stall
// without stalling the ROM pipeline.
//
// Output handshake: out_valid/out_ready. A pair transfers on every rising
// edge where out_valid && out_ready. While out_valid is high and out_ready is
// low, out_data_1/out_data_2/out_last hold steady. out_valid never depends
// on out_ready.
module coeff_rom_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 3,
  parameter int ROM_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_pairs,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_enable,
  output logic [ADDR_WIDTH-1:0] rom_addr_1,
  output logic [ADDR_WIDTH-1:0] rom_addr_2,
  input  logic [DATA_WIDTH-1:0] rom_data_1,
  input  logic [DATA_WIDTH-1:0] rom_data_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data_1,
  output logic [DATA_WIDTH-1:0] out_data_2,
  output logic                  out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(ROM_LATENCY + 1);

  localparam logic [ADDR_WIDTH-1:0] A_ONE   = 1;
  localparam logic [PTR_W-1:0]      P_ONE   = 1;
  localparam logic [PTR_W-1:0]      P_MAX   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]      C_ONE   = 1;
  localparam logic [CNT_W-1:0]      C_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] num_q;
  logic [ADDR_WIDTH-1:0] k;

  // Tag pipeline: one stage per ROM latency cycle, the last stage lines up
  // with the rom_data_* belonging to that issue.
  logic [ROM_LATENCY-1:0] tag_v;
  logic [ROM_LATENCY-1:0] tag_last;
  logic [INF_W-1:0]       inflight;

  // Output FIFO storage and bookkeeping.
  logic [DATA_WIDTH-1:0] mem_d1 [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d2 [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic                  push;
  logic                  pop;
  logic                  head_last;
  logic                  credit_ok;
  logic                  issue;
  logic                  is_last_pair;
  logic [ADDR_WIDTH-1:0] off_even;
  logic [ADDR_WIDTH-1:0] addr_even;
  logic [ADDR_WIDTH-1:0] addr_odd;

  assign push       = tag_v[ROM_LATENCY-1];
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign head_last  = mem_last[rd_ptr];
  assign out_data_1 = out_valid ? mem_d1[rd_ptr] : '0;
  assign out_data_2 = out_valid ? mem_d2[rd_ptr] : '0;
  assign out_last   = out_valid && head_last;

  // Pair addresses wrap naturally modulo the ROM size.
  assign off_even     = {k[ADDR_WIDTH-2:0], 1'b0};
  assign addr_even    = base_q + off_even;
  assign addr_odd     = addr_even + A_ONE;
  assign is_last_pair = (k == (num_q - A_ONE));

  // Count valid tags still travelling through the ROM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + INF_W'(tag_v[i]);
    end
  end

  // Credit: every in-flight read already owns a FIFO slot. A pop this cycle
  // frees a slot at the same edge the new issue claims one.
  always_comb begin
    credit_ok = (int'(fifo_count) + int'(inflight)) < (FIFO_DEPTH + (pop ? 1 : 0));
  end

  assign issue      = (state == ISSUE) && credit_ok;
  assign rom_enable = (inflight != '0) || issue;

  // Job control FSM with registered busy/done/ROM addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      k          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_addr_1 <= '0;
      rom_addr_2 <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_pairs != '0) begin
              base_q <= base_addr;
              num_q  <= num_pairs;
              k      <= '0;
              busy   <= 1'b1;
              state  <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= FINISH;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            rom_addr_1 <= addr_even;
            rom_addr_2 <= addr_odd;
            k          <= k + A_ONE;
            if (is_last_pair) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift issue tags along with the ROM read latency; reset drops stale reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v    <= '0;
      tag_last <= '0;
    end else begin
      tag_v[0]    <= issue;
      tag_last[0] <= issue && is_last_pair;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == P_MAX) ? '0 : wr_ptr + P_ONE;
      if (pop)  rd_ptr <= (rd_ptr == P_MAX) ? '0 : rd_ptr + P_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + C_ONE;
        2'b01:   fifo_count <= fifo_count - C_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage: capture ROM data when its tag arrives.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d1[wr_ptr]   <= rom_data_1;
      mem_d2[wr_ptr]   <= rom_data_2;
      mem_last[wr_ptr] <= tag_last[ROM_LATENCY-1];
    end
  end

  // The credit scheme must never let an arriving pair find the FIFO full.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (fifo_count == C_FULL)));

endmodule

// File: tb/tb_coeff_rom_sequencer.sv
// Directed bench for coeff_rom_sequencer with a behavioural dual-port ROM.
`timescale 1ns/1ps
module tb_coeff_rom_sequencer;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int PW = 2 * DW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] num_pairs = '0;
  logic          busy;
  logic          done;
  logic          rom_enable;
  logic [AW-1:0] rom_addr_1;
  logic [AW-1:0] rom_addr_2;
  logic [DW-1:0] rom_data_1 = '0;
  logic [DW-1:0] rom_data_2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data_1;
  logic [DW-1:0] out_data_2;
  logic          out_last;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] exp_q[$];
  logic [4:0]    ctl_exp;
  logic [4:0]    ctl_got;

  coeff_rom_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ROM_LATENCY(3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .num_pairs (num_pairs),
    .busy      (busy),
    .done      (done),
    .rom_enable(rom_enable),
    .rom_addr_1(rom_addr_1),
    .rom_addr_2(rom_addr_2),
    .rom_data_1(rom_data_1),
    .rom_data_2(rom_data_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data_1(out_data_1),
    .out_data_2(out_data_2),
    .out_last  (out_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model ----------------
  // The sequencer's registered address is the first of the three latency
  // stages; two more registers here deliver data on the third cycle.
  logic [DW-1:0] rom_mem [8];
  logic [DW-1:0] rom_q1 = '0;
  logic [DW-1:0] rom_q2 = '0;

  initial begin
    rom_mem[0] = 32'h11112222;
    rom_mem[1] = 32'h33334444;
    rom_mem[2] = 32'h55556666;
    rom_mem[3] = 32'h77778888;
    rom_mem[4] = 32'h9999aaaa;
    rom_mem[5] = 32'hbbbbcccc;
    rom_mem[6] = 32'hddddeeee;
    rom_mem[7] = 32'hffff0000;
  end

  always @(posedge clk) begin
    rom_q1     <= rom_mem[rom_addr_1];
    rom_q2     <= rom_mem[rom_addr_2];
    rom_data_1 <= rom_q1;
    rom_data_2 <= rom_q2;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns 1 ns after the accepting edge (c = 0).
  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
    start     = 1'b1;
    base_addr = b;
    num_pairs = n;
    step();
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (rom_enable !== 1'b0) begin n_bad++; $display("FAIL rst_rom_enable: got %b want 0", rom_enable); end
    n_cmp++; if (rom_addr_1 !== 3'd0) begin n_bad++; $display("FAIL rst_addr1: got %0d want 0", rom_addr_1); end
    n_cmp++; if (rom_addr_2 !== 3'd0) begin n_bad++; $display("FAIL rst_addr2: got %0d want 0", rom_addr_2); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_last: got %b want 0", out_last); end
    n_cmp++; if (out_data_1 !== 32'h0) begin n_bad++; $display("FAIL rst_data1: got %h want 0", out_data_1); end
    n_cmp++; if (out_data_2 !== 32'h0) begin n_bad++; $display("FAIL rst_data2: got %h want 0", out_data_2); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    exp_q.delete();
    exp_q.push_back({32'h11112222, 32'h33334444, 1'b0});
    exp_q.push_back({32'h55556666, 32'h77778888, 1'b0});
    exp_q.push_back({32'h9999aaaa, 32'hbbbbcccc, 1'b0});
    exp_q.push_back({32'hddddeeee, 32'hffff0000, 1'b1});
    out_ready = 1'b1;
    start_job(3'd0, 3'd4);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      ctl_got = {out_valid, out_last, busy, done, rom_enable};
      ctl_exp = {(c >= 4 && c <= 7), (c == 7), (c <= 7), (c == 8), (c <= 6)};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++; $display("FAIL basic_ctl c=%0d: got %b want %b (valid,last,busy,done,rom_en)", c, ctl_got, ctl_exp);
      end
      if (c == 1) begin
        n_cmp++;
        if ({rom_addr_1, rom_addr_2} !== {3'd0, 3'd1}) begin
          n_bad++; $display("FAIL basic_addr0: got %0d/%0d want 0/1", rom_addr_1, rom_addr_2);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({rom_addr_1, rom_addr_2} !== {3'd6, 3'd7}) begin
          n_bad++; $display("FAIL basic_addr3: got %0d/%0d want 6/7", rom_addr_1, rom_addr_2);
        end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL basic_data c=%0d: got %h want nothing", c, {out_data_1, out_data_2, out_last});
        end else begin
          if ({out_data_1, out_data_2, out_last} !== exp_q[0]) begin
            n_bad++; $display("FAIL basic_data c=%0d: got %h want %h", c, {out_data_1, out_data_2, out_last}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL basic_left: got %0d undelivered want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    exp_q.delete();
    exp_q.push_back({32'hffff0000, 32'h11112222, 1'b1});
    out_ready = 1'b1;
    start_job(3'd7, 3'd1);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      ctl_got = {out_valid, out_last, busy, done, rom_enable};
      ctl_exp = {(c == 4), (c == 4), (c <= 4), (c == 5), (c <= 3)};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++; $display("FAIL wrap_ctl c=%0d: got %b want %b (valid,last,busy,done,rom_en)", c, ctl_got, ctl_exp);
      end
      if (c == 1) begin
        n_cmp++;
        if ({rom_addr_1, rom_addr_2} !== {3'd7, 3'd0}) begin
          n_bad++; $display("FAIL wrap_addr: got %0d/%0d want 7/0", rom_addr_1, rom_addr_2);
        end
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL wrap_data c=%0d: got %h want nothing", c, {out_data_1, out_data_2, out_last});
        end else begin
          if ({out_data_1, out_data_2, out_last} !== exp_q[0]) begin
            n_bad++; $display("FAIL wrap_data c=%0d: got %h want %h", c, {out_data_1, out_data_2, out_last}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_left: got %0d undelivered want 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    exp_q.delete();
    exp_q.push_back({32'h11112222, 32'h33334444, 1'b0});
    exp_q.push_back({32'h55556666, 32'h77778888, 1'b0});
    exp_q.push_back({32'h9999aaaa, 32'hbbbbcccc, 1'b0});
    exp_q.push_back({32'hddddeeee, 32'hffff0000, 1'b1});
    out_ready = 1'b0;
    start_job(3'd0, 3'd4);
    for (int c = 0; c <= 15; c++) begin
      out_ready = (c >= 10);
      @(negedge clk);
      ctl_got = {out_valid, out_last, busy, done, rom_enable};
      ctl_exp = {(c >= 4 && c <= 13), (c == 13), (c <= 13), (c == 14), (c <= 6)};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++; $display("FAIL stall_ctl c=%0d: got %b want %b (valid,last,busy,done,rom_en)", c, ctl_got, ctl_exp);
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stall_data c=%0d: got %h want nothing", c, {out_data_1, out_data_2, out_last});
        end else begin
          if ({out_data_1, out_data_2, out_last} !== exp_q[0]) begin
            n_bad++; $display("FAIL stall_data c=%0d: got %h want %h", c, {out_data_1, out_data_2, out_last}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_left: got %0d undelivered want 0", exp_q.size()); end
  endtask

  task automatic test_toggle();
    exp_q.delete();
    exp_q.push_back({32'h55556666, 32'h77778888, 1'b0});
    exp_q.push_back({32'h9999aaaa, 32'hbbbbcccc, 1'b0});
    exp_q.push_back({32'hddddeeee, 32'hffff0000, 1'b1});
    out_ready = 1'b1;
    start_job(3'd2, 3'd3);
    for (int c = 0; c <= 11; c++) begin
      out_ready = ((c % 2) == 0);
      @(negedge clk);
      ctl_got = {out_valid, out_last, busy, done, rom_enable};
      ctl_exp = {(c >= 4 && c <= 8), (c == 7 || c == 8), (c <= 8), (c == 9), (c <= 5)};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++; $display("FAIL toggle_ctl c=%0d: got %b want %b (valid,last,busy,done,rom_en)", c, ctl_got, ctl_exp);
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL toggle_data c=%0d: got %h want nothing", c, {out_data_1, out_data_2, out_last});
        end else begin
          if ({out_data_1, out_data_2, out_last} !== exp_q[0]) begin
            n_bad++; $display("FAIL toggle_data c=%0d: got %h want %h", c, {out_data_1, out_data_2, out_last}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL toggle_left: got %0d undelivered want 0", exp_q.size()); end
  endtask

  task automatic test_empty();
    out_ready = 1'b1;
    start_job(3'd3, 3'd0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      ctl_got = {out_valid, out_last, busy, done, rom_enable};
      ctl_exp = {1'b0, 1'b0, 1'b0, (c == 0), 1'b0};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++; $display("FAIL empty_ctl c=%0d: got %b want %b (valid,last,busy,done,rom_en)", c, ctl_got, ctl_exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_job();
    out_ready = 1'b1;
    start_job(3'd0, 3'd4);
    for (int c = 0; c <= 11; c++) begin
      if (c == 1) reset = 1'b1;
      if (c == 2) reset = 1'b0;
      @(negedge clk);
      if (c == 2) begin
        n_cmp++;
        if ({rom_addr_1, rom_addr_2} !== {3'd0, 3'd0}) begin
          n_bad++; $display("FAIL midrst_addr: got %0d/%0d want 0/0", rom_addr_1, rom_addr_2);
        end
        n_cmp++;
        if ({out_data_1, out_data_2} !== 64'h0) begin
          n_bad++; $display("FAIL midrst_data: got %h/%h want 0/0", out_data_1, out_data_2);
        end
      end
      if (c >= 2) begin
        ctl_got = {out_valid, out_last, busy, done, rom_enable};
        n_cmp++;
        if (ctl_got !== 5'b00000) begin
          n_bad++; $display("FAIL midrst_ctl c=%0d: got %b want 00000 (valid,last,busy,done,rom_en)", c, ctl_got);
        end
      end
      @(posedge clk);
      #1;
    end
    // A fresh job after the abort must run normally.
    exp_q.delete();
    exp_q.push_back({32'h9999aaaa, 32'hbbbbcccc, 1'b0});
    exp_q.push_back({32'hddddeeee, 32'hffff0000, 1'b1});
    start_job(3'd4, 3'd2);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      ctl_got = {out_valid, out_last, busy, done, rom_enable};
      ctl_exp = {(c == 4 || c == 5), (c == 5), (c <= 5), (c == 6), (c <= 4)};
      n_cmp++;
      if (ctl_got !== ctl_exp) begin
        n_bad++; $display("FAIL restart_ctl c=%0d: got %b want %b (valid,last,busy,done,rom_en)", c, ctl_got, ctl_exp);
      end
      if (out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL restart_data c=%0d: got %h want nothing", c, {out_data_1, out_data_2, out_last});
        end else begin
          if ({out_data_1, out_data_2, out_last} !== exp_q[0]) begin
            n_bad++; $display("FAIL restart_data c=%0d: got %h want %h", c, {out_data_1, out_data_2, out_last}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL restart_left: got %0d undelivered want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_toggle();
    test_empty();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
